// File: rtl/door_controller.sv
// Automatic door sequencer: turns the presence sensor into timed open/close
// motor commands with a travel position counter and an open-hold timer.
module door_controller #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int HOLD_CYCLES   = 16,
    parameter int POS_W         = 4,
    parameter int HOLD_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             doorSen,
    input  logic             doorLock,
    output logic             motorOpen,
    output logic             motorClose,
    output logic             doorOpen,
    output logic             doorClosed,
    output logic [POS_W-1:0] doorPos,
    output logic [1:0]       doorState
);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } stateT;

    localparam logic [POS_W-1:0]  POS_FULL  = POS_W'(TRAVEL_CYCLES);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(TRAVEL_CYCLES - 1);
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    stateT             state;
    stateT             stateNext;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  posNext;
    logic [HOLD_W-1:0] holdCnt;
    logic [HOLD_W-1:0] holdCntNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLOSED;
            pos     <= '0;
            holdCnt <= '0;
        end else begin
            state   <= stateNext;
            pos     <= posNext;
            holdCnt <= holdCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        posNext     = pos;
        holdCntNext = holdCnt;
        case (state)
            CLOSED: begin
                if (doorSen && !doorLock) begin
                    stateNext = OPENING;
                end
            end
            OPENING: begin
                // A reversal on the very first closing edge re-enters here at
                // full travel, so finish on >= to keep pos from running past open.
                if (pos >= POS_LAST) begin
                    posNext     = POS_FULL;
                    holdCntNext = '0;
                    stateNext   = OPEN;
                end else begin
                    posNext = pos + POS_ONE;
                end
            end
            OPEN: begin
                if (doorSen) begin
                    holdCntNext = '0;
                end else if (holdCnt == HOLD_LAST) begin
                    holdCntNext = '0;
                    stateNext   = CLOSING;
                end else begin
                    holdCntNext = holdCnt + HOLD_W'(1);
                end
            end
            CLOSING: begin
                // Safety reversal wins over both the step and the final close.
                if (doorSen) begin
                    stateNext = OPENING;
                end else if (pos <= POS_ONE) begin
                    posNext   = '0;
                    stateNext = CLOSED;
                end else begin
                    posNext = pos - POS_ONE;
                end
            end
            default: begin
                stateNext   = CLOSED;
                posNext     = '0;
                holdCntNext = '0;
            end
        endcase
    end

    assign motorOpen  = (state == OPENING);
    assign motorClose = (state == CLOSING);
    assign doorOpen   = (state == OPEN);
    assign doorClosed = (state == CLOSED);
    assign doorPos    = pos;
    assign doorState  = state;

endmodule
